serial_sub16: RTL and testbench

SERIAL_SUB16 -- requirements
Module: serial_sub16

---
 rtl/serial_sub16_pkg.sv | 15 +
 rtl/serial_sub16_sub4.sv | 17 +
 rtl/serial_sub16.sv | 97 +++++++++
 tb/tb_serial_sub16.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub16_pkg.sv
// Shared constants and FSM state encoding for the nibble-serial 16-bit subtractor.
package serial_sub16_pkg;

  localparam int WIDTH   = 16;
  localparam int NIB_W   = 4;
  localparam int NUM_NIB = 4;
  localparam int IDX_W   = $clog2(NUM_NIB);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_sub16_sub4.sv
// Combinational 4-bit subtract with borrow in/out: s = a - b - bin.
module sub4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] s,
  output logic       bout
);

  logic [4:0] diff;

  // A negative 5-bit result sets bit 4, which is exactly the borrow out.
  assign diff = {1'b0, a} - {1'b0, b} - {4'b0000, bin};
  assign s    = diff[3:0];
  assign bout = diff[4];

endmodule

// File: rtl/serial_sub16.sv
// Nibble-serial 16-bit subtractor: one shared sub4 walks LSB to MSB over four CALC cycles,
// then result and flags are published together on entry to DONE.
module serial_sub16
  import serial_sub16_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] x,
  input  logic [15:0] y,
  output logic        busy,
  output logic        done,
  output logic [15:0] z,
  output logic        sign,
  output logic        zero,
  output logic        borrow,
  output logic        parity,
  output logic        overflow
);

  state_t                   state, state_next;
  logic [IDX_W-1:0]         idx;
  logic                     bin_q;
  logic [WIDTH-1:0]         x_q, y_q;
  logic [WIDTH-NIB_W-1:0]   acc;
  logic [NIB_W-1:0]         nib_s;
  logic                     nib_bout;
  logic                     last_nib;
  logic                     start_ok;
  logic [WIDTH-1:0]         z_final;

  sub4 u_sub4 (
    .a    (x_q[idx*NIB_W +: NIB_W]),
    .b    (y_q[idx*NIB_W +: NIB_W]),
    .bin  (bin_q),
    .s    (nib_s),
    .bout (nib_bout)
  );

  assign last_nib = (idx == IDX_W'(NUM_NIB - 1));
  assign start_ok = start && (state != CALC);
  // Lower nibbles come from the shift accumulator; the top nibble is the one just computed.
  assign z_final  = {nib_s, acc};
  assign busy     = (state == CALC);
  assign done     = (state == DONE);

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (last_nib) state_next = DONE;
      DONE:    state_next = start ? CALC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      bin_q    <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      acc      <= '0;
      z        <= '0;
      sign     <= 1'b0;
      zero     <= 1'b0;
      borrow   <= 1'b0;
      parity   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_next;
      if (start_ok) begin
        x_q   <= x;
        y_q   <= y;
        idx   <= '0;
        bin_q <= 1'b0;
      end else if (state == CALC) begin
        acc   <= {nib_s, acc[WIDTH-NIB_W-1:NIB_W]};
        bin_q <= nib_bout;
        idx   <= idx + 1'b1;
        if (last_nib) begin
          z        <= z_final;
          sign     <= z_final[WIDTH-1];
          zero     <= ~|z_final;
          parity   <= ~^z_final;
          borrow   <= nib_bout;
          overflow <= (x_q[WIDTH-1] & ~y_q[WIDTH-1] & ~z_final[WIDTH-1]) |
                      (~x_q[WIDTH-1] & y_q[WIDTH-1] & z_final[WIDTH-1]);
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_sub16.sv
// Randomized and directed bench for serial_sub16 against an arithmetic reference model.
module tb_serial_sub16;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] x, y;
  logic        busy, done, sign, zero, borrow, parity, overflow;
  logic [15:0] z;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [15:0] z;
    logic        sign;
    logic        zero;
    logic        borrow;
    logic        parity;
    logic        overflow;
  } res_t;

  serial_sub16 dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y),
    .busy(busy), .done(done), .z(z), .sign(sign), .zero(zero),
    .borrow(borrow), .parity(parity), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [15:0] a, input logic [15:0] b);
    res_t r;
    int   d;
    d          = int'($signed(a)) - int'($signed(b));
    r.z        = a - b;
    r.sign     = (r.z >= 16'h8000);
    r.zero     = (r.z == 16'h0000);
    r.borrow   = (a < b);
    r.parity   = ($countones(r.z) % 2 == 0);
    r.overflow = (d > 32767) || (d < -32768);
    return r;
  endfunction

  function automatic res_t observed();
    return '{z: z, sign: sign, zero: zero, borrow: borrow, parity: parity, overflow: overflow};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; x = 16'h1111; y = 16'h0001;
    step();
    step();
    total++;
    if ({busy, done} !== 2'b00 || observed() !== '0) begin
      bad++;
      $display("FAIL reset_state: busy=%b done=%b res=%h, want all zero", busy, done, observed());
    end
    rst = 1'b0; start = 1'b0;
    step();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: busy=%b want 0", busy);
    end
  endtask

  // Full latency/flag check for one operation; start accepted at the first edge.
  task automatic test_directed();
    logic [15:0] tx[4] = '{16'h0005, 16'h0003, 16'h8000, 16'h1234};
    logic [15:0] ty[4] = '{16'h0003, 16'h0005, 16'h0001, 16'h1234};
    res_t exp_r;
    for (int v = 0; v < 4; v++) begin
      exp_r = model(tx[v], ty[v]);
      x = tx[v]; y = ty[v]; start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 0; c < 4; c++) begin
        total++;
        if ({busy, done} !== 2'b10) begin
          bad++;
          $display("FAIL dir%0d_busy_c%0d: busy=%b done=%b want 1 0", v, c, busy, done);
        end
        if (c < 3) step();
      end
      step();
      total++;
      if ({busy, done} !== 2'b01 || observed() !== exp_r) begin
        bad++;
        $display("FAIL dir%0d_result: busy=%b done=%b res=%h want 0 1 %h", v, busy, done, observed(), exp_r);
      end
      step();
      total++;
      if (done !== 1'b0 || observed() !== exp_r) begin
        bad++;
        $display("FAIL dir%0d_hold: done=%b res=%h want 0 %h", v, done, observed(), exp_r);
      end
    end
  endtask

  task automatic test_random();
    res_t        exp_r;
    logic [15:0] a, b;
    for (int n = 0; n < 24; n++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if (n % 6 == 1) b = a;
      if (n % 6 == 2) a = 16'h8000;
      if (n % 6 == 3) b = 16'h8000;
      if (n % 6 == 4) a = 16'h7FFF;
      exp_r = model(a, b);
      x = a; y = b; start = 1'b1;
      step();
      start = 1'b0; x = 16'($urandom); y = 16'($urandom);
      step(); step(); step(); step();
      total++;
      if (done !== 1'b1 || observed() !== exp_r) begin
        bad++;
        $display("FAIL rand%0d x=%h y=%h: done=%b res=%h want 1 %h", n, a, b, done, observed(), exp_r);
      end
      repeat ($urandom_range(0, 2)) step();
    end
  endtask

  task automatic test_ignore_busy();
    x = 16'h0010; y = 16'h0001; start = 1'b1;
    step();
    start = 1'b0;
    step();
    x = 16'hFFFF; y = 16'h0001; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    total++;
    if (done !== 1'b1 || z !== 16'h000F) begin
      bad++;
      $display("FAIL ignore_busy: done=%b z=%h want 1 000f", done, z);
    end
    step();
  endtask

  task automatic test_abort_reset();
    logic seen_done = 1'b0;
    x = 16'h4321; y = 16'h1234; start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (done) seen_done = 1'b1;
      step();
    end
    total++;
    if (seen_done || busy !== 1'b0 || observed() !== '0) begin
      bad++;
      $display("FAIL abort_reset: seen_done=%b busy=%b res=%h want 0 0 0", seen_done, busy, observed());
    end
    x = 16'h0100; y = 16'h0200; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step(); step();
    total++;
    if (done !== 1'b1 || observed() !== model(16'h0100, 16'h0200)) begin
      bad++;
      $display("FAIL after_abort: done=%b res=%h want 1 %h", done, observed(), model(16'h0100, 16'h0200));
    end
    step();
  endtask

  task automatic test_back_to_back();
    res_t ra = model(16'hA5A5, 16'h5A5A);
    res_t rb = model(16'h0001, 16'hFFFF);
    x = 16'hA5A5; y = 16'h5A5A; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step(); step();
    total++;
    if (done !== 1'b1 || observed() !== ra) begin
      bad++;
      $display("FAIL b2b_first: done=%b res=%h want 1 %h", done, observed(), ra);
    end
    x = 16'h0001; y = 16'hFFFF; start = 1'b1;
    step();
    start = 1'b0;
    total++;
    if ({busy, done} !== 2'b10 || observed() !== ra) begin
      bad++;
      $display("FAIL b2b_accept: busy=%b done=%b res=%h want 1 0 %h", busy, done, observed(), ra);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      total++;
      if (done !== 1'b0) begin
        bad++;
        $display("FAIL b2b_early_done_c%0d: done=%b want 0", c, done);
      end
    end
    step();
    total++;
    if (done !== 1'b1 || observed() !== rb) begin
      bad++;
      $display("FAIL b2b_second: done=%b res=%h want 1 %h", done, observed(), rb);
    end
    step();
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; x = '0; y = '0;
    #1;
    test_reset();
    test_directed();
    test_random();
    test_ignore_busy();
    test_abort_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
